// File: rtl/pe_pkg.sv
// Shared types and helpers for the weight-stationary PE tile.
// Operand fields are sized for the widest supported IN_W; unused upper bits hold extension.
package pe_pkg;

    localparam bit SAT_SIGNED   = 1'b1;
    localparam bit SAT_UNSIGNED = 1'b0;

    localparam int unsigned PE_MAX_IN_W = 32;
    localparam int unsigned PE_NARROW_W = 64;

    typedef struct packed {
        logic [PE_MAX_IN_W-1:0] act;
        logic [PE_MAX_IN_W-1:0] wgt;
        logic                   last;
        logic                   valid;
    } pe_beat_t;

    typedef struct packed {
        logic                   sat;
        logic [PE_NARROW_W-1:0] data;
    } pe_sat_t;

    // acc must already be sign- or zero-extended to PE_NARROW_W according to signed_mode.
    function automatic pe_sat_t sat_narrow(input logic [PE_NARROW_W-1:0] acc,
                                           input logic                   signed_mode,
                                           input int unsigned            out_w);
        logic signed [PE_NARROW_W-1:0] s_max;
        logic        [PE_NARROW_W-1:0] u_max;
        pe_sat_t                       res;
        s_max    = $signed((64'd1 << (out_w - 1)) - 64'd1);
        u_max    = (64'd1 << out_w) - 64'd1;
        res.sat  = 1'b0;
        res.data = acc;
        if (signed_mode == SAT_SIGNED) begin
            if ($signed(acc) > s_max) begin
                res.sat  = 1'b1;
                res.data = s_max;
            end else if ($signed(acc) < ~s_max) begin
                res.sat  = 1'b1;
                res.data = ~s_max;
            end
        end else if (acc > u_max) begin
            res.sat  = 1'b1;
            res.data = u_max;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_wgt_regfile.sv
// Weight register file: one synchronous write port, one combinational read port.
// A read of the entry being written in the same cycle returns the previous contents.
module pe_wgt_regfile #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic wr_hit;
        assign wr_hit = wr_en_i && (wr_addr_i == AW'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[g] <= '0;
            end else if (wr_hit) begin
                mem_q[g] <= wr_data_i;
            end
        end
    end

    // Out-of-range addresses (non power-of-two depth) read as zero.
    assign rd_data_o = (32'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/pe_pipelined.sv
// Pipelined weight-stationary MAC: S1 operand capture, S2 multiply, S3 accumulate,
// then a single-entry saturating result register with valid/ready backpressure.
module pe_pipelined
    import pe_pkg::*;
#(
    parameter int unsigned  IN_W       = 16,
    parameter int unsigned  ACC_W      = 40,
    parameter int unsigned  OUT_W      = 32,
    parameter int unsigned  WREG_DEPTH = 4,
    parameter bit           SIGNED     = 1'b1,
    localparam int unsigned WA_W       = $clog2(WREG_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wgt_wr_en_i,
    input  logic [WA_W-1:0]  wgt_wr_addr_i,
    input  logic [IN_W-1:0]  wgt_wr_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_act_i,
    input  logic [WA_W-1:0]  in_wsel_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_sat_o
);

    if (ACC_W < 2 * IN_W || OUT_W < IN_W || OUT_W > ACC_W || ACC_W > PE_NARROW_W ||
        OUT_W >= PE_NARROW_W || IN_W > PE_MAX_IN_W || WREG_DEPTH < 2) begin : g_param_check
        $error("pe_pipelined: unsupported parameter combination");
    end

    logic [IN_W-1:0]        rf_rd_data;
    pe_beat_t               s1_d, s1_q;
    logic [PE_NARROW_W-1:0] act_x, wgt_x;
    logic [ACC_W-1:0]       prod_d, prod_q;
    logic                   s2_valid_q, s2_last_q;
    logic [ACC_W-1:0]       sum;
    logic [ACC_W-1:0]       acc_d, acc_q;
    logic                   first_d, first_q;
    logic [PE_NARROW_W-1:0] sum_x;
    pe_sat_t                sat_res;
    logic                   stall, s3_fire, out_load;
    logic                   out_valid_d, out_valid_q;
    logic [OUT_W-1:0]       out_data_d, out_data_q;
    logic                   out_sat_d, out_sat_q;

    function automatic logic [PE_MAX_IN_W-1:0] widen_in(input logic [IN_W-1:0] v);
        logic [PE_MAX_IN_W-1:0] r;
        if (SIGNED) begin
            r = PE_MAX_IN_W'($signed(v));
        end else begin
            r = PE_MAX_IN_W'(v);
        end
        return r;
    endfunction

    pe_wgt_regfile #(
        .DEPTH (WREG_DEPTH),
        .W     (IN_W),
        .AW    (WA_W)
    ) u_wgt_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wgt_wr_en_i),
        .wr_addr_i (wgt_wr_addr_i),
        .wr_data_i (wgt_wr_data_i),
        .rd_addr_i (in_wsel_i),
        .rd_data_o (rf_rd_data)
    );

    // Only a finished dot product that cannot drain blocks the pipe; partial beats keep moving.
    assign stall      = s2_valid_q && s2_last_q && out_valid_q && !out_ready_i;
    assign in_ready_o = !stall;

    always_comb begin
        s1_d.act   = widen_in(in_act_i);
        s1_d.wgt   = widen_in(rf_rd_data);
        s1_d.last  = in_last_i;
        s1_d.valid = in_valid_i;
    end

    // Operands are extended per mode, so the low ACC_W bits of the wide product are exact.
    always_comb begin
        if (SIGNED) begin
            act_x = PE_NARROW_W'($signed(s1_q.act));
            wgt_x = PE_NARROW_W'($signed(s1_q.wgt));
        end else begin
            act_x = PE_NARROW_W'(s1_q.act);
            wgt_x = PE_NARROW_W'(s1_q.wgt);
        end
        prod_d = ACC_W'(act_x * wgt_x);
    end

    always_comb begin
        sum      = first_q ? prod_q : acc_q + prod_q;
        s3_fire  = !stall && s2_valid_q;
        out_load = s3_fire && s2_last_q;
        acc_d    = acc_q;
        first_d  = first_q;
        if (s3_fire) begin
            acc_d   = sum;
            first_d = s2_last_q;
        end
    end

    always_comb begin
        if (SIGNED) begin
            sum_x = PE_NARROW_W'($signed(sum));
        end else begin
            sum_x = PE_NARROW_W'(sum);
        end
        sat_res     = sat_narrow(sum_x, SIGNED, OUT_W);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_load) begin
            out_valid_d = 1'b1;
            out_data_d  = OUT_W'(sat_res.data);
            out_sat_d   = sat_res.sat;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            prod_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            first_q    <= 1'b1;
        end else if (!stall) begin
            s1_q       <= s1_d;
            prod_q     <= prod_d;
            s2_valid_q <= s1_q.valid;
            s2_last_q  <= s1_q.last;
            acc_q      <= acc_d;
            first_q    <= first_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_pe_pipelined.sv
// Bench for pe_pipelined: three configurations share one stimulus stream and are checked
// against an arithmetic dot-product model with saturation computed from integer bounds.
module tb_pe_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wgt_wr_en;
    logic [1:0]  wgt_wr_addr;
    logic [15:0] wgt_wr_data;
    logic        in_valid;
    logic [15:0] in_act;
    logic [1:0]  in_wsel;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_data_a;
    logic [15:0] out_data_b, out_data_c;
    logic        out_sat_a, out_sat_b, out_sat_c;

    always #5 clk = ~clk;

    pe_pipelined #(.IN_W(16), .ACC_W(40), .OUT_W(32), .WREG_DEPTH(4), .SIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wgt_wr_en_i(wgt_wr_en), .wgt_wr_addr_i(wgt_wr_addr),
        .wgt_wr_data_i(wgt_wr_data), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
        .in_act_i(in_act), .in_wsel_i(in_wsel), .in_last_i(in_last),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
        .out_sat_o(out_sat_a)
    );

    pe_pipelined #(.IN_W(16), .ACC_W(40), .OUT_W(16), .WREG_DEPTH(4), .SIGNED(1'b1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .wgt_wr_en_i(wgt_wr_en), .wgt_wr_addr_i(wgt_wr_addr),
        .wgt_wr_data_i(wgt_wr_data), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .in_act_i(in_act), .in_wsel_i(in_wsel), .in_last_i(in_last),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
        .out_sat_o(out_sat_b)
    );

    pe_pipelined #(.IN_W(16), .ACC_W(40), .OUT_W(16), .WREG_DEPTH(4), .SIGNED(1'b0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .wgt_wr_en_i(wgt_wr_en), .wgt_wr_addr_i(wgt_wr_addr),
        .wgt_wr_data_i(wgt_wr_data), .in_valid_i(in_valid), .in_ready_o(in_ready_c),
        .in_act_i(in_act), .in_wsel_i(in_wsel), .in_last_i(in_last),
        .out_valid_o(out_valid_c), .out_ready_i(out_ready), .out_data_o(out_data_c),
        .out_sat_o(out_sat_c)
    );

    typedef struct {
        logic [31:0] a;
        logic        sa;
        logic [15:0] b;
        logic        sb;
        logic [15:0] c;
        logic        sc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    longint      run_s = 0;
    longint      run_u = 0;
    logic [15:0] model_w [4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_result();
        exp_t   e;
        longint hi32 = 64'sd2147483647;
        longint lo32 = -64'sd2147483648;
        longint hi16 = 64'sd32767;
        longint lo16 = -64'sd32768;
        e.sa = (run_s > hi32) || (run_s < lo32);
        e.a  = 32'((run_s > hi32) ? hi32 : ((run_s < lo32) ? lo32 : run_s));
        e.sb = (run_s > hi16) || (run_s < lo16);
        e.b  = 16'((run_s > hi16) ? hi16 : ((run_s < lo16) ? lo16 : run_s));
        e.sc = (run_u > 64'sd65535);
        e.c  = e.sc ? 16'hFFFF : 16'(run_u);
        exp_q.push_back(e);
        run_s = 0;
        run_u = 0;
    endfunction

    function automatic void model_accept(input logic [15:0] a, input logic [1:0] ws,
                                         input logic l);
        run_s += longint'($signed(a)) * longint'($signed(model_w[ws]));
        run_u += longint'(a) * longint'(model_w[ws]);
        if (l) push_result();
    endfunction

    // Checks every emitted result of all three configurations against the model queue.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid_a), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_s32", 64'(out_data_a), 64'(mon_e.a));
                check("sat_s32", 64'(out_sat_a), 64'(mon_e.sa));
                check("valid_s16", 64'(out_valid_b), 64'd1);
                check("data_s16", 64'(out_data_b), 64'(mon_e.b));
                check("sat_s16", 64'(out_sat_b), 64'(mon_e.sb));
                check("valid_u16", 64'(out_valid_c), 64'd1);
                check("data_u16", 64'(out_data_c), 64'(mon_e.c));
                check("sat_u16", 64'(out_sat_c), 64'(mon_e.sc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wgt_write(input logic [1:0] a, input logic [15:0] d);
        wgt_wr_en = 1'b1;
        wgt_wr_addr = a;
        wgt_wr_data = d;
        @(negedge clk);
        model_w[a] = d;
        @(posedge clk);
        #1;
        wgt_wr_en = 1'b0;
    endtask

    task automatic beat_w(input logic [15:0] a, input logic [1:0] ws, input logic l,
                          input logic we, input logic [1:0] wa, input logic [15:0] wd);
        bit taken;
        int n;
        taken = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_act = a;
        in_wsel = ws;
        in_last = l;
        wgt_wr_en = we;
        wgt_wr_addr = wa;
        wgt_wr_data = wd;
        while (!taken && n < 200) begin
            @(negedge clk);
            if (in_ready_a) begin
                taken = 1'b1;
                last_acc_cyc = cyc;
                model_accept(a, ws, l);
            end
            // The weight read above sees the old entry; the write lands at this edge.
            if (wgt_wr_en) model_w[wa] = wd;
            @(posedge clk);
            #1;
            wgt_wr_en = 1'b0;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check("beat_accepted", 64'(taken), 64'd1);
    endtask

    task automatic beat(input logic [15:0] a, input logic [1:0] ws, input logic l);
        beat_w(a, ws, l, 1'b0, 2'd0, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wgt_wr_en = 1'b0;
        wgt_wr_addr = '0;
        wgt_wr_data = '0;
        in_valid = 1'b0;
        in_act = '0;
        in_wsel = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) model_w[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_out_data", 64'(out_data_a), 64'd0);
        check("rst_out_sat", 64'(out_sat_a), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        @(posedge clk);
        #1;

        // 4-beat dot product with latency check: 1*3 + 2*(-2) + 3*5 + 4*7 = 42
        wgt_write(2'd0, 16'd3);
        wgt_write(2'd1, 16'hFFFE);
        wgt_write(2'd2, 16'd5);
        wgt_write(2'd3, 16'd7);
        beat(16'd1, 2'd0, 1'b0);
        beat(16'd2, 2'd1, 1'b0);
        beat(16'd3, 2'd2, 1'b0);
        beat(16'd4, 2'd3, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("latency_valid", 64'(out_valid_a), 64'(k == 3));
            if (k == 3) begin
                check("dot4_data", 64'(out_data_a), 64'd42);
                check("dot4_sat", 64'(out_sat_a), 64'd0);
            end
        end
        @(posedge clk);
        #1;

        // Back-to-back 2-beat products: 11 then 30
        beat(16'd2, 2'd0, 1'b0);
        beat(16'd1, 2'd2, 1'b1);
        beat(16'd4, 2'd3, 1'b0);
        beat(16'hFFFF, 2'd1, 1'b1);
        idle(6);
        check("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Saturation corners
        wgt_write(2'd0, 16'h7FFF);
        beat(16'h7FFF, 2'd0, 1'b0);
        beat(16'h7FFF, 2'd0, 1'b1);
        wgt_write(2'd1, 16'hFFFF);
        beat(16'hFFFF, 2'd1, 1'b0);
        beat(16'hFFFF, 2'd1, 1'b1);
        beat(16'h8000, 2'd0, 1'b0);
        beat(16'h8000, 2'd0, 1'b1);
        idle(6);
        check("sat_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: first result must hold while the second last waits in S2
        out_ready = 1'b0;
        beat(16'd2, 2'd2, 1'b0);
        beat(16'd3, 2'd3, 1'b1);
        beat(16'd1, 2'd2, 1'b0);
        beat(16'd1, 2'd3, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready_a), 64'd0);
            check("bp_out_valid", 64'(out_valid_a), 64'd1);
            check("bp_hold_data", 64'(out_data_a), 64'(exp_q[0].a));
            check("bp_hold_31", 64'(out_data_a), 64'd31);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(6);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Same-cycle write and read of entry 1: old value 4, then new value 9
        wgt_write(2'd1, 16'd4);
        beat_w(16'd1, 2'd1, 1'b1, 1'b1, 2'd1, 16'd9);
        beat(16'd1, 2'd1, 1'b1);
        idle(6);
        check("wr_rd_drained", 64'(exp_q.size()), 64'd0);

        // Randomized streams, concurrent weight writes, bubbles and random backpressure
        rand_rdy = 1'b1;
        for (int dp = 0; dp < 16; dp++) begin
            int nb;
            nb = int'($urandom_range(1, 6));
            for (int b = 0; b < nb; b++) begin
                beat_w(16'($urandom), 2'($urandom_range(0, 3)), 1'(b == nb - 1),
                       1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                       16'($urandom));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        idle(8);
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with a held result and a partial sum in flight
        out_ready = 1'b0;
        wgt_write(2'd2, 16'd5);
        beat(16'd2, 2'd2, 1'b1);
        beat(16'd3, 2'd2, 1'b0);
        idle(2);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid_a), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid_a), 64'd0);
        check("async_rst_data", 64'(out_data_a), 64'd0);
        check("async_rst_sat", 64'(out_sat_a), 64'd0);
        exp_q.delete();
        run_s = 0;
        run_u = 0;
        for (int i = 0; i < 4; i++) model_w[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        wgt_write(2'd0, 16'd3);
        beat(16'd5, 2'd0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) check("post_rst_15", 64'(out_data_a), 64'd15);
        end
        @(posedge clk);
        #1;
        idle(4);
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
